// File: rtl/pn_pkg.sv
// rtl/pn_pkg.sv - opcodes, error codes and FSM state encoding for pn_stack_eval
package pn_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_ABS = 2'd3;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
  localparam logic [2:0] ERR_OVERFLOW  = 3'd2;
  localparam logic [2:0] ERR_TOKLEN    = 3'd3;
  localparam logic [2:0] ERR_BADOP     = 3'd4;
  localparam logic [2:0] ERR_LEFTOVER  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECV   = 3'd1,
    ST_EVAL   = 3'd2,
    ST_FINISH = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

endpackage

// File: rtl/pn_stack_eval_if.sv
// rtl/pn_stack_eval_if.sv - token input / result output bundle for pn_stack_eval
interface pn_stack_eval_if #(
  parameter int DW  = 32,
  parameter int OPW = 3
);
  logic           in_valid;
  logic           mode;
  logic           operator;
  logic [OPW-1:0] in;
  logic           busy;
  logic           out_valid;
  logic [DW-1:0]  out;
  logic           err;
  logic [2:0]     err_code;

  // token source side
  modport master (
    output in_valid, mode, operator, in,
    input  busy, out_valid, out, err, err_code
  );

  // evaluator side
  modport slave (
    input  in_valid, mode, operator, in,
    output busy, out_valid, out, err, err_code
  );
endinterface

// File: rtl/pn_alu.sv
// rtl/pn_alu.sv - combinational two-operand ALU; PN_SAT_EN selects saturating arithmetic
module pn_alu
  import pn_pkg::*;
#(
  parameter int DW  = 32,
  parameter int OPW = 3
) (
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] opcode,
  output logic [DW-1:0]  res,
  output logic           bad_op
);
  logic [DW-1:0] sum_r, dif_r, prod_r, abs_r;

`ifdef PN_SAT_EN
  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MAX_NEG = {1'b1, {(DW-1){1'b0}}};

  logic [DW:0]     sum_x, dif_x;
  logic [2*DW-1:0] prod_x;

  // a DW+1 bit result overflowed when its top two bits disagree
  function automatic logic [DW-1:0] clamp1(input logic [DW:0] v);
    if (v[DW] != v[DW-1]) return v[DW] ? MAX_NEG : MAX_POS;
    return v[DW-1:0];
  endfunction

  // exact-width results clamped into the signed DW range
  always_comb begin
    sum_x  = {a[DW-1], a} + {b[DW-1], b};
    dif_x  = {a[DW-1], a} - {b[DW-1], b};
    prod_x = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    sum_r  = clamp1(sum_x);
    dif_r  = clamp1(dif_x);
    if ((&prod_x[2*DW-1:DW-1]) || !(|prod_x[2*DW-1:DW-1])) prod_r = prod_x[DW-1:0];
    else prod_r = prod_x[2*DW-1] ? MAX_NEG : MAX_POS;
    if (sum_r[DW-1]) abs_r = (sum_r == MAX_NEG) ? MAX_POS : -sum_r;
    else abs_r = sum_r;
  end
`else
  // modulo 2^DW results; negating most-negative leaves it unchanged
  always_comb begin
    sum_r  = a + b;
    dif_r  = a - b;
    prod_r = a * b;
    abs_r  = sum_r[DW-1] ? -sum_r : sum_r;
  end
`endif

  // opcode select; anything above 3 is reported as a bad opcode
  always_comb begin
    bad_op = |(opcode >> 2);
    case (opcode[1:0])
      OP_ADD:  res = sum_r;
      OP_SUB:  res = dif_r;
      OP_MUL:  res = prod_r;
      OP_ABS:  res = abs_r;
      default: res = sum_r;
    endcase
  end
endmodule

// File: rtl/pn_stack_eval.sv
// rtl/pn_stack_eval.sv - Polish-notation expression evaluator (PN_SAT_EN: saturating ALU)
module pn_stack_eval
  import pn_pkg::*;
#(
  parameter int DW        = 32,
  parameter int OPW       = 3,
  parameter int MAX_TOK   = 16,
  parameter int STK_DEPTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  pn_stack_eval_if.slave bus
);
  localparam int SPW = $clog2(STK_DEPTH + 1);
  localparam int SIW = $clog2(STK_DEPTH);
  localparam int TCW = $clog2(MAX_TOK + 1);
  localparam int TIW = $clog2(MAX_TOK);
  localparam logic [SPW-1:0] SP_FULL  = SPW'(STK_DEPTH);
  localparam logic [TCW-1:0] TOK_FULL = TCW'(MAX_TOK);

  state_t         state, state_nx;
  logic           mode_q;
  logic [TCW-1:0] tok_cnt, tok_nx;
  logic [SPW-1:0] sp, sp_nx;
  logic [2:0]     err_q, err_nx;
  logic [OPW:0]   tok_buf [MAX_TOK];
  logic [DW-1:0]  stk [STK_DEPTH];

  logic           accept, cur_post, buf_full, rev, eval_now, buf_we;
  logic           t_op;
  logic [OPW-1:0] t_val;
  logic [SIW-1:0] top_i, below_i, stk_wi;
  logic           stk_we;
  logic [DW-1:0]  stk_wd, alu_a, alu_b, alu_res;
  logic           alu_bad;

  // token source and stack addressing; prefix scan swaps the operand roles
  always_comb begin
    accept   = bus.in_valid && (state == ST_IDLE || state == ST_RECV);
    cur_post = (state == ST_IDLE) ? bus.mode : mode_q;
    buf_full = (tok_cnt == TOK_FULL);
    rev      = (state == ST_EVAL);
    eval_now = rev || (accept && cur_post && !buf_full);
    buf_we   = accept && !cur_post && !buf_full;
    if (rev) {t_op, t_val} = tok_buf[TIW'(tok_cnt - TCW'(1))];
    else begin
      t_op  = bus.operator;
      t_val = bus.in;
    end
    top_i   = SIW'(sp - SPW'(1));
    below_i = SIW'(sp - SPW'(2));
    alu_a   = rev ? stk[top_i] : stk[below_i];
    alu_b   = rev ? stk[below_i] : stk[top_i];
  end

  pn_alu #(.DW(DW), .OPW(OPW)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .opcode (t_val),
    .res    (alu_res),
    .bad_op (alu_bad)
  );

  // effect of one token on stack, stack pointer and first-error latch
  always_comb begin
    stk_we = 1'b0;
    stk_wi = SIW'(sp);
    stk_wd = {{(DW-OPW){1'b0}}, t_val};
    sp_nx  = sp;
    err_nx = err_q;
    tok_nx = tok_cnt;
    if (eval_now && err_q == ERR_OK) begin
      if (!t_op) begin
        if (sp == SP_FULL) err_nx = ERR_OVERFLOW;
        else begin
          stk_we = 1'b1;
          sp_nx  = sp + SPW'(1);
        end
      end else if (alu_bad) err_nx = ERR_BADOP;
      else if (sp < SPW'(2)) err_nx = ERR_UNDERFLOW;
      else begin
        stk_we = 1'b1;
        stk_wi = below_i;
        stk_wd = alu_res;
        sp_nx  = sp - SPW'(1);
      end
    end else if (accept && buf_full && err_q == ERR_OK) begin
      err_nx = ERR_TOKLEN;
    end
    if (accept && !buf_full) tok_nx = tok_cnt + TCW'(1);
    if (rev) tok_nx = tok_cnt - TCW'(1);
    if (state == ST_FINISH && err_q == ERR_OK && sp != SPW'(1)) err_nx = ERR_LEFTOVER;
    if (state == ST_OUT) begin
      sp_nx  = '0;
      err_nx = ERR_OK;
      tok_nx = '0;
    end
  end

  // control registers, cleared asynchronously so a reset drops any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sp      <= '0;
      err_q   <= ERR_OK;
      tok_cnt <= '0;
      mode_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      sp      <= sp_nx;
      err_q   <= err_nx;
      tok_cnt <= tok_nx;
      if (state == ST_IDLE && bus.in_valid) mode_q <= bus.mode;
    end
  end

  // stack and prefix token storage; contents only matter once written
  always_ff @(posedge clk) begin
    if (stk_we) stk[stk_wi] <= stk_wd;
    if (buf_we) tok_buf[TIW'(tok_cnt)] <= {bus.operator, bus.in};
  end

  // next state and result outputs
  always_comb begin
    state_nx      = state;
    bus.busy      = (state != ST_IDLE);
    bus.out_valid = (state == ST_OUT);
    bus.err       = 1'b0;
    bus.err_code  = ERR_OK;
    bus.out       = '0;
    case (state)
      ST_IDLE:   if (bus.in_valid) state_nx = ST_RECV;
      ST_RECV:   if (!bus.in_valid) state_nx = mode_q ? ST_FINISH : ST_EVAL;
      ST_EVAL:   if (tok_cnt <= TCW'(1)) state_nx = ST_FINISH;
      ST_FINISH: state_nx = ST_OUT;
      ST_OUT: begin
        state_nx     = ST_IDLE;
        bus.err      = (err_q != ERR_OK);
        bus.err_code = err_q;
        if (err_q == ERR_OK) bus.out = stk[0];
      end
      default:   state_nx = ST_IDLE;
    endcase
  end
endmodule
